// File: rtl/dds_pkg.sv
// Shared DDS definitions.
// Holds the common sample width and the state encoding for the SPI DAC
// output stage.
package dds_pkg;

  // Output sample width of the DDS core. It is also the default frame width
  // of the DAC serializer.
  localparam int DDS_WAVE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } spi_state_e;

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the DDS core and the SPI DAC output stage.
//   sample_i        sample word offered by the producer
//   sample_valid_i  sample_i is valid this cycle
//   sample_ready_o  the consumer's holding register is empty
// The master modport is the producer (the DDS core). The slave modport is
// dac_spi_tx.
interface dac_spi_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] sample_i;
  logic                  sample_valid_i;
  logic                  sample_ready_o;

  modport master (output sample_i, output sample_valid_i, input sample_ready_o);
  modport slave  (input sample_i, input sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/dac_spi_tx.sv
// SPI DAC transmitter: mode 0, MSB first, one chip-select frame per sample.
// A one-entry holding register accepts the next sample while the current
// frame shifts out.
//   dds_clk_i   sole clock, rising edge
//   dds_rst_ni  asynchronous active-low reset
//   smp         sample handshake (slave side)
//   sclk_o      SPI clock, idles low
//   mosi_o      SPI data, changes only while sclk_o is low
//   cs_no       DAC chip select, active-low
//   busy_o      frame in progress or holding register full
//   overrun_o   one-cycle pulse after a sample was dropped (valid && !ready)
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH     = DDS_WAVE_WIDTH,
  parameter int CLK_DIV        = 2,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic         dds_clk_i,
  input  logic         dds_rst_ni,
  dac_spi_tx_if.slave  smp,
  output logic         sclk_o,
  output logic         mosi_o,
  output logic         cs_no,
  output logic         busy_o,
  output logic         overrun_o
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = 8'(CS_IDLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  spi_state_e            state;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shreg;
  logic [7:0]            div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [7:0]            gap_cnt;
  logic                  accept;
  logic                  unload;

  assign accept = smp.sample_valid_i && !hold_full;
  // The held sample moves to the shifter from IDLE, or on the final GAP
  // cycle so that back-to-back frames need no extra idle cycle.
  assign unload = hold_full &&
                  (state == ST_IDLE || (state == ST_GAP && gap_cnt == GAP_LAST));

  // Ready is taken straight from the register. It has no combinational path
  // from valid.
  assign smp.sample_ready_o = !hold_full;
  assign busy_o             = (state != ST_IDLE) || hold_full;

  // Holding register. Accept and unload never happen in the same cycle,
  // because ready is low while the register is full.
  always_ff @(posedge dds_clk_i or negedge dds_rst_ni) begin
    if (!dds_rst_ni) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= smp.sample_valid_i && hold_full;
      if (accept) begin
        hold_q    <= smp.sample_i;
        hold_full <= 1'b1;
      end else if (unload) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Frame FSM. The divider, bit counter and shift register are kept inline.
  always_ff @(posedge dds_clk_i or negedge dds_rst_ni) begin
    if (!dds_rst_ni) begin
      state   <= ST_IDLE;
      sclk_o  <= 1'b0;
      mosi_o  <= 1'b0;
      cs_no   <= 1'b1;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk_o  <= ~sclk_o;
            if (sclk_o) begin
              // Falling toggle: the DAC has sampled the current bit.
              if (bit_cnt == BIT_LAST) begin
                cs_no   <= 1'b1;
                mosi_o  <= 1'b0;
                gap_cnt <= '0;
                state   <= ST_GAP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                shreg   <= shreg << 1;
                mosi_o  <= shreg[DATA_WIDTH-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          // IDLE, or GAP with chip select held high.
          if (state == ST_GAP && gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 8'd1;
          end else if (hold_full) begin
            shreg   <= hold_q;
            mosi_o  <= hold_q[DATA_WIDTH-1];
            cs_no   <= 1'b0;
            sclk_o  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx.
// dut_a runs at the default timing: CLK_DIV=2, CS_IDLE_CYCLES=2.
// dut_b runs at the fastest timing: CLK_DIV=1, CS_IDLE_CYCLES=1.
// A per-DUT monitor decodes each frame from the SPI pins and checks the
// mode-0 rules continuously.
module tb_dac_spi_tx;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_tx_if #(.DATA_WIDTH(16)) ifa ();
  dac_spi_tx_if #(.DATA_WIDTH(16)) ifb ();

  logic sclk_a, mosi_a, cs_a, busy_a, ovr_a;
  logic sclk_b, mosi_b, cs_b, busy_b, ovr_b;

  dac_spi_tx #(.DATA_WIDTH(16), .CLK_DIV(2), .CS_IDLE_CYCLES(2)) dut_a (
    .dds_clk_i(clk), .dds_rst_ni(rst_n), .smp(ifa.slave),
    .sclk_o(sclk_a), .mosi_o(mosi_a), .cs_no(cs_a), .busy_o(busy_a), .overrun_o(ovr_a)
  );

  dac_spi_tx #(.DATA_WIDTH(16), .CLK_DIV(1), .CS_IDLE_CYCLES(1)) dut_b (
    .dds_clk_i(clk), .dds_rst_ni(rst_n), .smp(ifb.slave),
    .sclk_o(sclk_b), .mosi_o(mosi_b), .cs_no(cs_b), .busy_o(busy_b), .overrun_o(ovr_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- frame monitor ----------------
  typedef struct {
    logic [15:0] data;
    int nb;
    int fall;
    int rise;
    int first_r;
    int last_r;
  } frame_t;

  frame_t qa[$];
  frame_t qb[$];
  frame_t rec;

  logic [1:0] sclk_v, mosi_v, cs_v;
  assign sclk_v = {sclk_b, sclk_a};
  assign mosi_v = {mosi_b, mosi_a};
  assign cs_v   = {cs_b, cs_a};

  logic [1:0]  ps = 2'b00, pm = 2'b00, pc = 2'b11;
  bit          inf [2];
  int          nb [2], fall [2], fr [2], lr [2];
  logic [15:0] sh [2];
  int          spi_viol = 0;
  int          ovr_cnt_a = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      // Outside a frame, sclk and mosi must both be low.
      if (cs_v[d] === 1'b1 && (mosi_v[d] !== 1'b0 || sclk_v[d] !== 1'b0)) spi_viol++;
      // mosi may change only while sclk is low.
      if (sclk_v[d] === 1'b1 && mosi_v[d] !== pm[d]) spi_viol++;
      if (pc[d] === 1'b1 && cs_v[d] === 1'b0) begin
        inf[d] = 1'b1; nb[d] = 0; sh[d] = '0; fall[d] = cyc;
      end
      if (inf[d] && ps[d] === 1'b0 && sclk_v[d] === 1'b1) begin
        sh[d] = {sh[d][14:0], mosi_v[d]};
        if (nb[d] == 0) fr[d] = cyc;
        lr[d] = cyc;
        nb[d]++;
      end
      if (inf[d] && pc[d] === 1'b0 && cs_v[d] === 1'b1) begin
        rec = '{data: sh[d], nb: nb[d], fall: fall[d], rise: cyc, first_r: fr[d], last_r: lr[d]};
        if (d == 0) qa.push_back(rec);
        else        qb.push_back(rec);
        inf[d] = 1'b0;
      end
    end
    if (ovr_a === 1'b1) ovr_cnt_a++;
    ps = sclk_v; pm = mosi_v; pc = cs_v;
  end

  // ---------------- driver helpers ----------------
  task automatic push(input int d, input logic [15:0] s, output int acc);
    int k = 0;
    @(negedge clk);
    while (((d == 0) ? ifa.sample_ready_o : ifb.sample_ready_o) !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready", (d == 0) ? ifa.sample_ready_o : ifb.sample_ready_o, 1);
    if (d == 0) begin ifa.sample_i = s; ifa.sample_valid_i = 1'b1; end
    else        begin ifb.sample_i = s; ifb.sample_valid_i = 1'b1; end
    @(negedge clk);
    acc = cyc;
    // Drop valid and scramble the data bus. The frame already accepted must
    // not be affected.
    if (d == 0) begin ifa.sample_valid_i = 1'b0; ifa.sample_i = 16'($urandom); end
    else        begin ifb.sample_valid_i = 1'b0; ifb.sample_i = 16'($urandom); end
  endtask

  task automatic wait_q(input int d, input int n, input int budget);
    int k = 0;
    while (((d == 0) ? qa.size() : qb.size()) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", (d == 0) ? qa.size() : qb.size(), n);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] s;
    logic [15:0] exp_data;
    int exp_lat;    // accept edge to cs_no fall
    int exp_first;  // cs_no fall to first rising sclk
    int exp_span;   // first to last rising sclk
    int exp_len;    // cs_no fall to cs_no rise
  } vec_t;

  vec_t vt [6];
  int   acc, acc2, ovr0;

  initial begin
    vt[0] = '{16'hA5C3, 16'hA5C3, 1, 2, 60, 64};
    vt[1] = '{16'h0001, 16'h0001, 1, 2, 60, 64};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1, 2, 60, 64};
    vt[3] = '{16'h8000, 16'h8000, 1, 2, 60, 64};
    vt[4] = '{16'h0000, 16'h0000, 1, 2, 60, 64};
    vt[5] = '{16'h5A3C, 16'h5A3C, 1, 2, 60, 64};

    ifa.sample_i = '0; ifa.sample_valid_i = 1'b0;
    ifb.sample_i = '0; ifb.sample_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst_ready", ifa.sample_ready_o, 1);
    chk("rst_sclk",  sclk_a, 0);
    chk("rst_mosi",  mosi_a, 0);
    chk("rst_cs",    cs_a, 1);
    chk("rst_busy",  busy_a, 0);
    chk("rst_ovr",   ovr_a, 0);
    chk("rst_ready_b", ifb.sample_ready_o, 1);

    // Single frames from IDLE.
    for (int i = 0; i < 6; i++) begin
      qa.delete();
      push(0, vt[i].s, acc);
      chk("busy_after_accept", busy_a, 1);
      wait_q(0, 1, 200);
      if (qa.size() >= 1) begin
        chk("vec_data",  qa[0].data, vt[i].exp_data);
        chk("vec_bits",  qa[0].nb, 16);
        chk("vec_lat",   qa[0].fall - acc, vt[i].exp_lat);
        chk("vec_first", qa[0].first_r - qa[0].fall, vt[i].exp_first);
        chk("vec_span",  qa[0].last_r - qa[0].first_r, vt[i].exp_span);
        chk("vec_len",   qa[0].rise - qa[0].fall, vt[i].exp_len);
      end
      repeat (4) @(negedge clk);
      chk("vec_idle_busy", busy_a, 0);
      chk("vec_idle_cs", cs_a, 1);
    end

    // Continuous supply: frames start exactly 66 cycles apart.
    qa.delete();
    ovr0 = ovr_cnt_a;
    push(0, 16'h0001, acc);
    push(0, 16'hFFFF, acc);
    push(0, 16'h8000, acc);
    wait_q(0, 3, 400);
    if (qa.size() >= 3) begin
      chk("b2b_d0", qa[0].data, 16'h0001);
      chk("b2b_d1", qa[1].data, 16'hFFFF);
      chk("b2b_d2", qa[2].data, 16'h8000);
      chk("b2b_p01", qa[1].fall - qa[0].fall, 66);
      chk("b2b_p12", qa[2].fall - qa[1].fall, 66);
      chk("b2b_gap", qa[1].fall - qa[0].rise, 2);
    end
    chk("b2b_no_ovr", ovr_cnt_a - ovr0, 0);
    repeat (4) @(negedge clk);

    // Overrun: the third sample is offered while the holding register is full.
    qa.delete();
    ovr0 = ovr_cnt_a;
    push(0, 16'hC001, acc);
    push(0, 16'h7FFE, acc);
    @(negedge clk);
    chk("ovr_ready_low", ifa.sample_ready_o, 0);
    ifa.sample_i = 16'h0F0F; ifa.sample_valid_i = 1'b1;
    @(negedge clk);
    ifa.sample_valid_i = 1'b0;
    chk("ovr_pulse", ovr_a, 1);
    @(negedge clk);
    chk("ovr_pulse_end", ovr_a, 0);
    wait_q(0, 2, 400);
    repeat (200) @(negedge clk);
    chk("ovr_frames", qa.size(), 2);
    if (qa.size() >= 2) begin
      chk("ovr_d0", qa[0].data, 16'hC001);
      chk("ovr_d1", qa[1].data, 16'h7FFE);
    end
    chk("ovr_count", ovr_cnt_a - ovr0, 1);

    // CLK_DIV=1, CS_IDLE_CYCLES=1.
    qb.delete();
    push(1, 16'h1234, acc);
    push(1, 16'hBEEF, acc2);
    wait_q(1, 2, 300);
    if (qb.size() >= 2) begin
      chk("fast_d0",    qb[0].data, 16'h1234);
      chk("fast_d1",    qb[1].data, 16'hBEEF);
      chk("fast_lat",   qb[0].fall - acc, 1);
      chk("fast_first", qb[0].first_r - qb[0].fall, 1);
      chk("fast_span",  qb[0].last_r - qb[0].first_r, 30);
      chk("fast_len",   qb[0].rise - qb[0].fall, 32);
      chk("fast_gap",   qb[1].fall - qb[0].rise, 1);
      chk("fast_period", qb[1].fall - qb[0].fall, 33);
    end
    repeat (4) @(negedge clk);

    // Reset mid-frame, with a second sample waiting in the holding register.
    qa.delete();
    push(0, 16'hA5C3, acc);
    push(0, 16'h3C3C, acc);
    begin
      int k = 0;
      while (nb[0] < 8 && k < 200) begin @(negedge clk); k++; end
      chk("rst_mid_reached", (nb[0] >= 8) ? 1 : 0, 1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs",    cs_a, 1);
    chk("arst_sclk",  sclk_a, 0);
    chk("arst_mosi",  mosi_a, 0);
    chk("arst_ready", ifa.sample_ready_o, 1);
    chk("arst_busy",  busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 qa.delete();
    @(negedge clk);
    chk("post_rst_busy", busy_a, 0);
    push(0, 16'h5555, acc);
    wait_q(0, 1, 200);
    if (qa.size() >= 1) begin
      chk("post_rst_data", qa[0].data, 16'h5555);
      chk("post_rst_bits", qa[0].nb, 16);
    end
    repeat (200) @(negedge clk);
    chk("held_discarded", qa.size(), 1);

    chk("spi_protocol", spi_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Downstream output stage for the DDS datapath: accepts 16-bit output samples from the DDS core through a valid/ready handshake and serializes each one to an external SPI DAC (mode 0, MSB first, one chip-select frame per sample). A one-entry holding register lets the next sample be accepted while the current frame shifts out, so back-to-back frames need no idle cycles beyond the programmed chip-select gap.

## Interface
- DATA_WIDTH, 16, sample and SPI frame width in bits; equals the DDS output width.
- CLK_DIV, 2, SCLK half-period in dds_clk_i cycles; legal range 1..255.
- CS_IDLE_CYCLES, 2, cycles cs_no stays high between frames; legal range 1..255.

Ports:
- dds_clk_i  input  1  sole clock; all logic on its rising edge.
- dds_rst_ni  input  1  reset, asynchronous assert, active-low.
- sample_i  input  DATA_WIDTH  sample to transmit.
- sample_valid_i  input  1  sample_i valid this cycle.
- sample_ready_o  output  1  holding register empty; a transfer occurs on valid && ready.
- sclk_o  output  1  SPI clock, idles low.
- mosi_o  output  1  SPI data, changes only while sclk_o is low.
- cs_no  output  1  DAC chip select, active-low.
- busy_o  output  1  frame in progress or holding register full.
- overrun_o  output  1  one-cycle pulse: a sample was offered while not ready and was dropped.

## Operation
- Reset values: sample_ready_o=1, sclk_o=0, mosi_o=0, cs_no=1, busy_o=0, overrun_o=0; holding register empty; FSM in IDLE.
- Holding register: loaded on valid && ready; sample_ready_o = !hold_full, driven directly from the register with no combinational path from sample_valid_i. It empties on the edge its content moves to the shift register. Accept and unload never coincide, because ready is low whenever the register is full.
- Overrun: valid && !ready drops sample_i. The held sample is kept, and overrun_o pulses on the following cycle.
- IDLE: cs_no=1, sclk_o=0. If hold_full: load the shift register, cs_no→0, mosi_o→MSB, clear the divider and bit counters, go to SHIFT.
- SHIFT: the divider counts CLK_DIV cycles per half-period.
  - Each expiry toggles sclk_o.
  - On each falling toggle, shift and drive the next bit to mosi_o.
  - The DATA_WIDTH-th falling toggle instead sets cs_no=1, mosi_o=0 and goes to GAP.
- GAP: hold cs_no=1 for CS_IDLE_CYCLES cycles. On the final GAP edge, load directly if hold_full (as IDLE does), else go to IDLE.
- busy_o = (state != IDLE) || hold_full.
- Reset mid-frame: frame aborted immediately (cs_no high, sclk_o low); the held sample is discarded.
- sample_valid_i and sample_i changing mid-frame do not affect the frame in flight.

## Timing
- Let E0 be the accepting edge and E1 = E0+1.
- E1: cs_no falls, mosi_o = bit DATA_WIDTH-1.
- Rising SCLK edges fall at E1 + (2k+1)·CLK_DIV for k = 0..DATA_WIDTH-1; falling edges at E1 + 2k·CLK_DIV for k ≥ 1.
- E1 + 2·DATA_WIDTH·CLK_DIV: sclk_o falls and cs_no rises on the same edge.
- Frame period with continuous supply: 2·DATA_WIDTH·CLK_DIV + CS_IDLE_CYCLES cycles (66 at defaults).
- Accept-to-CS latency: 1 cycle from IDLE. From GAP, cs_no falls on the edge after the final GAP cycle.
- After a holding-to-shift transfer, sample_ready_o is high again at E1.
- Boundary CLK_DIV=1: sclk_o toggles every cycle, giving SCLK = dds_clk_i/2.

## Structure
- Shared package dds_pkg:
  - FSM state encodings (IDLE, SHIFT, GAP).
  - DDS_WAVE_WIDTH = 16, shared with the DDS core and this block's DATA_WIDTH default.
- Single module with no sub-modules. The divider counter, bit counter and shift register are inline; each is under 20 lines, and splitting them out adds nothing.
- Counter widths: divider 8 bits, bit counter clog2(DATA_WIDTH)+1, gap counter 8 bits.

## Test plan
- Reset then single sample 0xA5C3 at defaults → cs_no low 1 cycle after accept; 16 rising SCLK edges sample bits 1010_0101_1100_0011 MSB first; cs_no high 64 cycles after falling.
- Valid held continuously with samples 0x0001, 0xFFFF, 0x8000 → frames start exactly 66 cycles apart, data bit-exact, no overrun_o.
- Two samples accepted, third offered while ready is low → overrun_o pulses once; the third sample is never transmitted; the first two are intact.
- CLK_DIV=1, CS_IDLE_CYCLES=1, sample 0x1234 → SCLK period 2 cycles; frame length 32 cycles plus a 1-cycle gap; mosi_o stable at every rising edge.
- dds_rst_ni asserted mid-frame (after bit 7) → cs_no=1, sclk_o=0, mosi_o=0 asynchronously; after release, ready=1, busy_o=0, and the next sample 0x5555 transmits cleanly.
- Sample 0xFFFF → mosi_o=0 outside the frame and never changes while sclk_o is high (SPI assertion checker on all tests).
